// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - state encoding, lamp patterns and direction encoding for traffic_light_ctrl
// FLASH_MODE_EN adds the FLASH state encoding.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_NS_GREEN  = 3'd0,
    ST_NS_YELLOW = 3'd1,
    ST_ALL_RED_A = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_ALL_RED_B = 3'd5,
    ST_PED_WALK  = 3'd6
`ifdef FLASH_MODE_EN
    , ST_FLASH   = 3'd7
`endif
  } state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  typedef struct packed {
    lamp_t ns;
    lamp_t ew;
    logic  walk;
  } lamps_t;

  localparam lamp_t LAMP_OFF    = 3'b000;
  localparam lamp_t LAMP_RED    = 3'b100;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b001;

  // Anything not explicitly a go/caution state shows both reds, including illegal codes.
  function automatic lamps_t decode_lamps(input state_t s);
    lamps_t l;
    l = '{ns: LAMP_RED, ew: LAMP_RED, walk: 1'b0};
    case (s)
      ST_NS_GREEN:  l.ns   = LAMP_GREEN;
      ST_NS_YELLOW: l.ns   = LAMP_YELLOW;
      ST_EW_GREEN:  l.ew   = LAMP_GREEN;
      ST_EW_YELLOW: l.ew   = LAMP_YELLOW;
      ST_PED_WALK:  l.walk = 1'b1;
      default:      ;
    endcase
    return l;
  endfunction

  function automatic state_t green_of(input dir_t d);
    return (d == DIR_NS) ? ST_NS_GREEN : ST_EW_GREEN;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// rtl/traffic_light_ctrl_phase_timer.sv - clearable phase counter with expiry compare
// expired is high on the last cycle of a phase of the supplied length.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [TW:0]   length,
  output logic [TW-1:0] count,
  output logic          expired
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TW'(1);
    end
  end

  assign expired = ({1'b0, count} == (length - (TW+1)'(1)));

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - actuated two-road intersection controller with pedestrian walk phase
// Optional FLASH_MODE_EN adds flash_en input and a flashing FLASH state.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN    = 10,
  parameter int MAX_GREEN    = 30,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 8,
  parameter int TW           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic       NS_red,
  output logic       NS_yellow,
  output logic       NS_green,
  output logic       EW_red,
  output logic       EW_yellow,
  output logic       EW_green,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_o
`ifdef FLASH_MODE_EN
  ,
  input  logic       flash_en
`endif
);

  localparam logic [TW:0] LEN_MIN_GREEN = (TW+1)'(MIN_GREEN);
  localparam logic [TW:0] LEN_MAX_GREEN = (TW+1)'(MAX_GREEN);
  localparam logic [TW:0] LEN_YELLOW    = (TW+1)'(YELLOW_TIME);
  localparam logic [TW:0] LEN_ALL_RED   = (TW+1)'(ALL_RED_TIME);
  localparam logic [TW:0] LEN_WALK      = (TW+1)'(WALK_TIME);

  state_t        state;
  state_t        state_next;
  dir_t          next_dir;
  dir_t          red_dir;
  logic [TW-1:0] timer;
  logic [TW:0]   phase_len;
  logic          phase_done;
  logic          timer_clear;
  logic          min_reached;
  logic          ns_cross_demand;
  logic          ew_cross_demand;
  lamps_t        lamps;

  phase_timer #(.TW(TW)) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (1'b1),
    .length  (phase_len),
    .count   (timer),
    .expired (phase_done)
  );

  assign min_reached     = ({1'b0, timer} >= (LEN_MIN_GREEN - (TW+1)'(1)));
  assign ns_cross_demand = ew_car | ped_pending;
  assign ew_cross_demand = ns_car | ped_pending;
  assign red_dir         = (state == ST_ALL_RED_A) ? DIR_EW : DIR_NS;

  always_comb begin
    phase_len = LEN_ALL_RED;
    case (state)
      ST_NS_GREEN, ST_EW_GREEN:   phase_len = LEN_MAX_GREEN;
      ST_NS_YELLOW, ST_EW_YELLOW: phase_len = LEN_YELLOW;
      ST_PED_WALK:                phase_len = LEN_WALK;
`ifdef FLASH_MODE_EN
      ST_FLASH:                   phase_len = LEN_YELLOW;
`endif
      default:                    phase_len = LEN_ALL_RED;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_NS_GREEN:
        if ((min_reached && ns_cross_demand) || phase_done) state_next = ST_NS_YELLOW;
      ST_NS_YELLOW:
        if (phase_done) state_next = ST_ALL_RED_A;
      ST_EW_GREEN:
        if ((min_reached && ew_cross_demand) || phase_done) state_next = ST_EW_YELLOW;
      ST_EW_YELLOW:
        if (phase_done) state_next = ST_ALL_RED_B;
      ST_ALL_RED_A, ST_ALL_RED_B:
        if (phase_done) begin
`ifdef FLASH_MODE_EN
          if (flash_en) state_next = ST_FLASH;
          else
`endif
          if (ped_pending) state_next = ST_PED_WALK;
          else             state_next = green_of(red_dir);
        end
      ST_PED_WALK:
        if (phase_done) state_next = green_of(next_dir);
`ifdef FLASH_MODE_EN
      ST_FLASH:
        if (!flash_en) state_next = ST_ALL_RED_B;
`endif
      default:
        state_next = ST_ALL_RED_B;
    endcase
  end

`ifdef FLASH_MODE_EN
  // In FLASH the timer wraps every YELLOW_TIME cycles to pace the blink.
  assign timer_clear = (state_next != state) || ((state == ST_FLASH) && phase_done);
`else
  assign timer_clear = (state_next != state);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_ALL_RED_B;
      next_dir    <= DIR_NS;
      ped_pending <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == ST_ALL_RED_A) || (state == ST_ALL_RED_B)) next_dir <= red_dir;
      // Entering the walk consumes the request, even if the button is pressed that same cycle.
      if ((state_next == ST_PED_WALK) && (state != ST_PED_WALK)) ped_pending <= 1'b0;
      else if (ped_req && (state != ST_PED_WALK))                 ped_pending <= 1'b1;
    end
  end

`ifdef FLASH_MODE_EN
  logic flash_off;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_off <= 1'b0;
    end else if (state != ST_FLASH) begin
      flash_off <= 1'b0;
    end else if (phase_done) begin
      flash_off <= ~flash_off;
    end
  end

  always_comb begin
    lamps = decode_lamps(state);
    if (state == ST_FLASH) begin
      lamps = flash_off ? '{ns: LAMP_OFF, ew: LAMP_OFF, walk: 1'b0}
                        : '{ns: LAMP_YELLOW, ew: LAMP_RED, walk: 1'b0};
    end
  end
`else
  always_comb begin
    lamps = decode_lamps(state);
  end
`endif

  assign NS_red    = lamps.ns.red;
  assign NS_yellow = lamps.ns.yellow;
  assign NS_green  = lamps.ns.green;
  assign EW_red    = lamps.ew.red;
  assign EW_yellow = lamps.ew.yellow;
  assign EW_green  = lamps.ew.green;
  assign walk      = lamps.walk;
  assign state_o   = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - self-checking bench for traffic_light_ctrl against a phase/duration model
module tb_traffic_light_ctrl;

  localparam int MIN_GREEN    = 10;
  localparam int MAX_GREEN    = 30;
  localparam int YELLOW_TIME  = 3;
  localparam int ALL_RED_TIME = 2;
  localparam int WALK_TIME    = 8;
  localparam int TW           = 8;

  // {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green, walk}
  localparam logic [6:0] V_NSG  = 7'b0011000;
  localparam logic [6:0] V_NSY  = 7'b0101000;
  localparam logic [6:0] V_EWG  = 7'b1000010;
  localparam logic [6:0] V_EWY  = 7'b1000100;
  localparam logic [6:0] V_RED  = 7'b1001000;
  localparam logic [6:0] V_WALK = 7'b1001001;

  logic       clk = 1'b0;
  logic       rst;
  logic       ns_car, ew_car, ped_req;
  logic       NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green, walk;
  logic       ped_pending;
  logic [2:0] state_o;
  logic [6:0] lv;
`ifdef FLASH_MODE_EN
  logic       flash_en = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {P_NSG, P_NSY, P_ARA, P_EWG, P_EWY, P_ARB, P_WALK} phase_e;
  phase_e m_phase, m_after;
  int     m_t;
  logic   m_pend;

  traffic_light_ctrl #(
    .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN), .YELLOW_TIME(YELLOW_TIME),
    .ALL_RED_TIME(ALL_RED_TIME), .WALK_TIME(WALK_TIME), .TW(TW)
  ) dut (
    .clk(clk), .rst(rst), .ns_car(ns_car), .ew_car(ew_car), .ped_req(ped_req),
    .NS_red(NS_red), .NS_yellow(NS_yellow), .NS_green(NS_green),
    .EW_red(EW_red), .EW_yellow(EW_yellow), .EW_green(EW_green),
    .walk(walk), .ped_pending(ped_pending), .state_o(state_o)
`ifdef FLASH_MODE_EN
    , .flash_en(flash_en)
`endif
  );

  always #5 clk = ~clk;

  assign lv = {NS_red, NS_yellow, NS_green, EW_red, EW_yellow, EW_green, walk};

  function automatic logic [6:0] exp_vec(input phase_e p);
    case (p)
      P_NSG:   return V_NSG;
      P_NSY:   return V_NSY;
      P_EWG:   return V_EWG;
      P_EWY:   return V_EWY;
      P_WALK:  return V_WALK;
      default: return V_RED;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_ARB;
    m_after = P_NSG;
    m_t     = 0;
    m_pend  = 1'b0;
  endtask

  // Each phase lasts its programmed number of cycles; greens may end early on cross demand.
  task automatic model_advance();
    phase_e nx;
    int     el;
    nx = m_phase;
    el = m_t + 1;
    case (m_phase)
      P_NSG:  if ((el >= MIN_GREEN && (ew_car || m_pend)) || el == MAX_GREEN) nx = P_NSY;
      P_EWG:  if ((el >= MIN_GREEN && (ns_car || m_pend)) || el == MAX_GREEN) nx = P_EWY;
      P_NSY:  if (el == YELLOW_TIME) nx = P_ARA;
      P_EWY:  if (el == YELLOW_TIME) nx = P_ARB;
      P_ARA:  if (el == ALL_RED_TIME) begin m_after = P_EWG; nx = m_pend ? P_WALK : P_EWG; end
      P_ARB:  if (el == ALL_RED_TIME) begin m_after = P_NSG; nx = m_pend ? P_WALK : P_NSG; end
      P_WALK: if (el == WALK_TIME) nx = m_after;
      default: nx = P_ARB;
    endcase
    if (nx == P_WALK && m_phase != P_WALK)  m_pend = 1'b0;
    else if (ped_req && m_phase != P_WALK) m_pend = 1'b1;
    m_t     = (nx == m_phase) ? m_t + 1 : 0;
    m_phase = nx;
  endtask

  task automatic check_model();
    check($sformatf("lamps@%0t", $time), 32'(lv), 32'(exp_vec(m_phase)));
    check($sformatf("pend@%0t", $time), 32'(ped_pending), 32'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_advance();
    @(negedge clk);
    check_model();
  endtask

  task automatic count_vec(input logic [6:0] v, output int n);
    n = 0;
    while (lv === v && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("async_reset_lamps", 32'(lv), 32'(V_RED));
    check("async_reset_pend", 32'(ped_pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_model();
  endtask

  initial begin
    int n;
    rst = 1'b1; ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_lamps", 32'(lv), 32'(V_RED));
    check("reset_pend", 32'(ped_pending), 32'd0);
    rst = 1'b0;
    model_reset();
    check_model();

    // No demand: greens rest to MAX_GREEN.
    count_vec(V_RED, n); check("idle_first_red", n, ALL_RED_TIME);
    count_vec(V_NSG, n); check("idle_ns_green", n, MAX_GREEN);
    count_vec(V_NSY, n); check("idle_ns_yellow", n, YELLOW_TIME);
    count_vec(V_RED, n); check("idle_all_red", n, ALL_RED_TIME);
    count_vec(V_EWG, n); check("idle_ew_green", n, MAX_GREEN);

    // Opposing car present from the start: minimum green.
    ew_car = 1'b1;
    do_reset();
    count_vec(V_RED, n); check("car_first_red", n, ALL_RED_TIME);
    count_vec(V_NSG, n); check("car_ns_green_min", n, MIN_GREEN);
    count_vec(V_NSY, n); check("car_ns_yellow", n, YELLOW_TIME);
    count_vec(V_RED, n); check("car_all_red", n, ALL_RED_TIME);
    check("car_ew_green", 32'(lv), 32'(V_EWG));
    ew_car = 1'b0;

    // Pedestrian pulse on NS green cycle 4.
    do_reset();
    count_vec(V_RED, n);
    repeat (3) step();
    ped_req = 1'b1; step(); ped_req = 1'b0;
    check("ped_latched", 32'(ped_pending), 32'd1);
    count_vec(V_NSG, n); check("ped_ns_green_total", n + 4, MIN_GREEN);
    count_vec(V_NSY, n); check("ped_ns_yellow", n, YELLOW_TIME);
    count_vec(V_RED, n); check("ped_all_red", n, ALL_RED_TIME);
    check("ped_clear_on_walk", 32'(ped_pending), 32'd0);
    count_vec(V_WALK, n); check("ped_walk_len", n, WALK_TIME);
    check("ped_then_ew_green", 32'(lv), 32'(V_EWG));

    // Button held across walk entry and throughout the walk is ignored.
    do_reset();
    count_vec(V_RED, n);
    ped_req = 1'b1; step(); ped_req = 1'b0;
    count_vec(V_NSG, n);
    count_vec(V_NSY, n);
    step();
    ped_req = 1'b1;
    step();
    check("walk_entry_clear_wins", 32'(ped_pending), 32'd0);
    count_vec(V_WALK, n); check("walk_len_req_held", n, WALK_TIME);
    ped_req = 1'b0;
    check("ped_ignored_in_walk", 32'(ped_pending), 32'd0);
    count_vec(V_EWG, n); check("no_demand_ew_green", n, MAX_GREEN);
    count_vec(V_EWY, n); check("ew_yellow_len", n, YELLOW_TIME);
    count_vec(V_RED, n); check("no_second_walk_red", n, ALL_RED_TIME);
    check("no_second_walk_ns", 32'(lv), 32'(V_NSG));

    // Asynchronous reset in the middle of EW yellow.
    ew_car = 1'b1;
    n = 0;
    while (lv !== V_EWY && n < 200) begin n++; step(); end
    check("reach_ew_yellow", 32'(lv), 32'(V_EWY));
    ew_car = 1'b0;
    step();
    do_reset();
    count_vec(V_RED, n); check("post_reset_red", n, ALL_RED_TIME);
    check("post_reset_ns_green", 32'(lv), 32'(V_NSG));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      ns_car  = ($urandom_range(0, 9) < 3);
      ew_car  = ($urandom_range(0, 9) < 3);
      ped_req = ($urandom_range(0, 39) == 0);
      step();
    end
    ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;

`ifdef FLASH_MODE_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flash_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2 * YELLOW_TIME; i++) begin
      check("flash_blink", 32'(lv), (i < YELLOW_TIME) ? 32'(7'b0101000) : 32'd0);
      @(negedge clk);
    end
    check("flash_blink_again", 32'(lv), 32'(7'b0101000));
    flash_en = 1'b0;
    @(negedge clk);
    check("flash_exit_red", 32'(lv), 32'(V_RED));
    @(negedge clk);
    check("flash_exit_red2", 32'(lv), 32'(V_RED));
    @(negedge clk);
    check("flash_exit_ns_green", 32'(lv), 32'(V_NSG));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
